hssl_handshake: RTL
===================

// Module: hssl_handshake
// PURPOSE
//  Link handshake engine for the HSSL GT datapath. Sits between the transceiver 32-bit user ports and the event pipelines.
//  Exchanges handshake words with the far end (SpiNNaker/peer) and asserts handshake_complete_out, which drives the transceiver's handshake-timeout reset.
//  Once complete, it passes user data through in both directions and drops back to handshake on link errors.
// PARAMETERS
//  PROTO_VERSION  8'h01  version byte sent/checked in handshake words
//  HS_PERIOD      64     cycles between handshake words while not complete (>=2)
//  HS_TIMEOUT     4096   cycles in HS_ACK without peer ack before retreat to HS_SEND
// PORTS
//  clk_in                in   1   tx_usrclk2 domain; rx ports already in this domain
//  reset_n_in            in   1   async assert, active-low
//  tx_data_out           out  32  to GT tx_data_in
//  tx_charisk_out        out  4   to GT tx_charisk_in
//  rx_data_in            in   32  from GT rx_data_out
//  rx_charisk_in         in   4   from GT rx_charisk_out
//  rx_disperr_in         in   4   from GT rx_disperr_out
//  rx_encerr_in          in   4   from GT rx_encerr_out
//  rx_reset_done_in      in   1   from GT rx_reset_done_out
//  tx_data_in            in   32  user tx word
//  tx_vld_in             in   1   user tx valid
//  tx_rdy_out            out  1   user tx ready
//  rx_data_out           out  32  user rx word
//  rx_vld_out            out  1   user rx valid (no backpressure)
//  handshake_complete_out out 1   link up
//  version_err_out       out  1   last handshake word had wrong version
// BEHAVIOUR
//  Words: IDLE = 32'hC5C5_C5BC/4'b0001; HS = {7'b0,ack, PROTO_VERSION, 8'hA5, 8'hBC}/4'b0001; data = charisk 4'b0000.
//  Rx classification (combinational on inputs): err = |(disperr|encerr); HS = charisk==4'b0001 & byte0==BC & byte1==A5;
//   control = charisk==4'b0001 & byte0==BC; data = charisk==0 & !err; anything else ignored.
//  Version check: HS with byte2!=PROTO_VERSION counts as no HS; sets version_err_out (cleared by next matching HS).
//  FSM (reset -> HS_SEND):
//   HS_SEND: HS(ack=0) when period cnt wraps, else IDLE. Matching HS (any ack) -> HS_ACK.
//   HS_ACK: HS(ack=1) when period cnt wraps, else IDLE. Matching HS ack=1 -> COMPLETE;
//     HS_TIMEOUT cycles without -> HS_SEND.
//   COMPLETE: matching HS ack=0 -> HS_ACK (peer restarted); err or !rx_reset_done_in -> HS_SEND.
//     HS ack=1 received -> one HS(ack=1) reply queued.
//   Any state: !rx_reset_done_in -> HS_SEND.
//  Period counter: restarts at 0 on every state entry, so first HS word goes out on entry cycle +1.
//  Tx path: all tx outputs registered; latency 1 cycle from accept to tx_data_out.
//   tx_rdy_out = (state==COMPLETE) & !reply_pending (combinational from regs).
//   In COMPLETE, priority: queued HS reply > user word (vld&rdy) > IDLE.
//  Rx path: rx_data_out/rx_vld_out registered, latency 1. rx_vld_out=1 only for data words in COMPLETE;
//   control/err words never forwarded.
//  handshake_complete_out = registered (state==COMPLETE); same cycle as first tx_rdy_out.
//  Simultaneous err and HS in COMPLETE: err wins (-> HS_SEND).
//  Reset values: tx_data_out=IDLE, tx_charisk_out=4'b0001, tx_rdy_out=0, rx_data_out=0, rx_vld_out=0,
//   handshake_complete_out=0, version_err_out=0, counters 0.
//  Reset mid-transfer: in-flight user word is dropped; user must re-offer after next complete.
// CONFIGURATION
//  HSSL_HS_CNT_EN defined: adds hs_restart_cnt_out[15:0] and rx_err_cnt_out[15:0].
//   hs_restart_cnt_out counts entries into HS_SEND from COMPLETE/HS_ACK.
//   rx_err_cnt_out counts cycles with err in COMPLETE.
//   Both saturate at 16'hFFFF and reset to 0.
//  Not defined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1. Loopback tx->rx (1-cycle delay), rx_reset_done=1: HS_SEND->HS_ACK->COMPLETE within 3*HS_PERIOD cycles; complete=1.
//  2. Complete, tx_vld_in with 32'hDEAD_BEEF: tx_data_out=DEADBEEF/4'b0000 next cycle; loopback rx_data_out=DEADBEEF, rx_vld_out=1.
//  3. Complete, inject rx_encerr_in=4'b0010 for 1 cycle: complete drops next cycle, tx_rdy_out=0; HS(ack=0) sent at entry+1.
//  4. Peer sends HS version 8'h02: version_err_out=1, FSM stays HS_SEND; matching HS clears flag and enters HS_ACK.
//  5. HS_ACK with no peer ack for 4096 cycles: returns to HS_SEND; with HSSL_HS_CNT_EN, hs_restart_cnt_out=1.
//  6. Complete, peer sends HS ack=0: -> HS_ACK, complete=0; HS(ack=1) sent; peer ack=1 -> complete again.

Source files
------------

// File: rtl/hssl_handshake.sv
// hssl_handshake: HSSL link handshake engine between the GT 32-bit user ports and the event pipelines.
// Define HSSL_HS_CNT_EN to add the saturating hs_restart_cnt_out / rx_err_cnt_out diagnostic counters.

module hssl_handshake #(
  parameter logic [7:0]  PROTO_VERSION = 8'h01,
  parameter int unsigned HS_PERIOD     = 64,
  parameter int unsigned HS_TIMEOUT    = 4096
) (
  input  logic        clk_in,
  input  logic        reset_n_in,
  output logic [31:0] tx_data_out,
  output logic [3:0]  tx_charisk_out,
  input  logic [31:0] rx_data_in,
  input  logic [3:0]  rx_charisk_in,
  input  logic [3:0]  rx_disperr_in,
  input  logic [3:0]  rx_encerr_in,
  input  logic        rx_reset_done_in,
  input  logic [31:0] tx_data_in,
  input  logic        tx_vld_in,
  output logic        tx_rdy_out,
  output logic [31:0] rx_data_out,
  output logic        rx_vld_out,
`ifdef HSSL_HS_CNT_EN
  output logic [15:0] hs_restart_cnt_out,
  output logic [15:0] rx_err_cnt_out,
`endif
  output logic        handshake_complete_out,
  output logic        version_err_out
);

  localparam logic [31:0] IDLE_WORD = 32'hC5C5_C5BC;
  localparam logic [3:0]  K_BYTE0   = 4'b0001;
  localparam logic [3:0]  K_NONE    = 4'b0000;
  localparam int unsigned CW        = $clog2(HS_PERIOD);
  localparam int unsigned TW        = $clog2(HS_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(HS_PERIOD - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(HS_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_HS_SEND  = 2'd0,
    ST_HS_ACK   = 2'd1,
    ST_COMPLETE = 2'd2
  } state_e;

  function automatic logic [31:0] hs_word(input logic ack);
    return {7'b0, ack, PROTO_VERSION, 8'hA5, 8'hBC};
  endfunction

  state_e          state_q, state_d;
  logic [CW-1:0]   per_cnt_q, per_cnt_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic            reply_q, reply_d;
  logic [31:0]     tx_data_q, tx_data_d;
  logic [3:0]      tx_k_q, tx_k_d;
  logic [31:0]     rx_data_q, rx_data_d;
  logic            rx_vld_q, rx_vld_d;
  logic            complete_q, complete_d;
  logic            ver_err_q, ver_err_d;

  logic rx_err, rx_ctrl, rx_hs, rx_hs_match, rx_hs_badver, rx_data_word, rx_ack;
  logic tx_accept;

  // Error words win over everything else, so a corrupted handshake word never counts as one.
  assign rx_err       = |(rx_disperr_in | rx_encerr_in);
  assign rx_ctrl      = (rx_charisk_in == K_BYTE0) && (rx_data_in[7:0] == 8'hBC);
  assign rx_hs        = rx_ctrl && (rx_data_in[15:8] == 8'hA5) && !rx_err;
  assign rx_hs_match  = rx_hs && (rx_data_in[23:16] == PROTO_VERSION);
  assign rx_hs_badver = rx_hs && (rx_data_in[23:16] != PROTO_VERSION);
  assign rx_ack       = rx_data_in[24];
  assign rx_data_word = (rx_charisk_in == K_NONE) && !rx_err;

  assign tx_rdy_out = (state_q == ST_COMPLETE) && !reply_q;
  assign tx_accept  = tx_vld_in && tx_rdy_out;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HS_SEND: begin
        if (rx_hs_match) state_d = ST_HS_ACK;
      end
      ST_HS_ACK: begin
        if (rx_hs_match && rx_ack)   state_d = ST_COMPLETE;
        else if (to_cnt_q == TO_LAST) state_d = ST_HS_SEND;
      end
      ST_COMPLETE: begin
        if (rx_err)                       state_d = ST_HS_SEND;
        else if (rx_hs_match && !rx_ack)  state_d = ST_HS_ACK;
      end
      default: state_d = ST_HS_SEND;
    endcase
    if (!rx_reset_done_in) state_d = ST_HS_SEND;
  end

  // Both counters restart on any state change so the first HS word leaves one cycle after entry.
  always_comb begin
    per_cnt_d = '0;
    to_cnt_d  = '0;
    if (state_d == state_q) begin
      per_cnt_d = (per_cnt_q == CNT_LAST) ? '0 : per_cnt_q + CW'(1);
      if (state_q == ST_HS_ACK) to_cnt_d = to_cnt_q + TW'(1);
    end
  end

  always_comb begin
    reply_d = reply_q;
    if (state_q == ST_COMPLETE) begin
      if (reply_q) reply_d = 1'b0;
      if (rx_hs_match && rx_ack) reply_d = 1'b1;
    end
    if (state_d != ST_COMPLETE) reply_d = 1'b0;
  end

  always_comb begin
    tx_data_d = IDLE_WORD;
    tx_k_d    = K_BYTE0;
    case (state_q)
      ST_HS_SEND: begin
        if (per_cnt_q == '0) tx_data_d = hs_word(1'b0);
      end
      ST_HS_ACK: begin
        if (per_cnt_q == '0) tx_data_d = hs_word(1'b1);
      end
      ST_COMPLETE: begin
        if (reply_q) begin
          tx_data_d = hs_word(1'b1);
        end else if (tx_accept) begin
          tx_data_d = tx_data_in;
          tx_k_d    = K_NONE;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    rx_vld_d   = (state_q == ST_COMPLETE) && rx_data_word;
    rx_data_d  = rx_vld_d ? rx_data_in : rx_data_q;
    complete_d = (state_d == ST_COMPLETE);
    ver_err_d  = ver_err_q;
    if (rx_hs_match)       ver_err_d = 1'b0;
    else if (rx_hs_badver) ver_err_d = 1'b1;
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q    <= ST_HS_SEND;
      per_cnt_q  <= '0;
      to_cnt_q   <= '0;
      reply_q    <= 1'b0;
      tx_data_q  <= IDLE_WORD;
      tx_k_q     <= K_BYTE0;
      rx_data_q  <= '0;
      rx_vld_q   <= 1'b0;
      complete_q <= 1'b0;
      ver_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      per_cnt_q  <= per_cnt_d;
      to_cnt_q   <= to_cnt_d;
      reply_q    <= reply_d;
      tx_data_q  <= tx_data_d;
      tx_k_q     <= tx_k_d;
      rx_data_q  <= rx_data_d;
      rx_vld_q   <= rx_vld_d;
      complete_q <= complete_d;
      ver_err_q  <= ver_err_d;
    end
  end

  assign tx_data_out            = tx_data_q;
  assign tx_charisk_out         = tx_k_q;
  assign rx_data_out            = rx_data_q;
  assign rx_vld_out             = rx_vld_q;
  assign handshake_complete_out = complete_q;
  assign version_err_out        = ver_err_q;

`ifdef HSSL_HS_CNT_EN
  logic [15:0] restart_cnt_q, restart_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    restart_cnt_d = restart_cnt_q;
    err_cnt_d     = err_cnt_q;
    if ((state_q != ST_HS_SEND) && (state_d == ST_HS_SEND) && (restart_cnt_q != 16'hFFFF))
      restart_cnt_d = restart_cnt_q + 16'd1;
    if ((state_q == ST_COMPLETE) && rx_err && (err_cnt_q != 16'hFFFF))
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      restart_cnt_q <= '0;
      err_cnt_q     <= '0;
    end else begin
      restart_cnt_q <= restart_cnt_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign hs_restart_cnt_out = restart_cnt_q;
  assign rx_err_cnt_out     = err_cnt_q;
`endif

endmodule
